// File: rtl/wt_sched_unit.sv
// wt_sched_unit: SHA-2 message schedule generator streaming W(t) and its round index to the HCU
module wt_sched_unit #(
  parameter int S_AXIS_DATA_WIDTH = 512,
  parameter int M_AXIS_DATA_WIDTH = 64
) (
  input  logic                         axi_aclk,
  input  logic                         axi_reset,
  input  logic                         en,
  input  logic [1:0]                   sha_type,
  input  logic [S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [M_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [6:0]                   m_axis_tuser,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         err
);
  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;
  localparam bit TWO_BEAT_BUS = S_AXIS_DATA_WIDTH == 512;
  state_t state, state_nx;
  logic mode64, last_blk, beat, two_beat, fin_beat, fin_round, s_acc, m_hs;
  logic [6:0] t, last_t;
  logic [63:0] win [16];
  logic [63:0] ld [16];
  logic [63:0] w_new;
  logic [1023:0] din;
  logic unused_sha_lsb;
  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction
  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction
  function automatic logic [63:0] bswap64(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 8; i++) y[8*i +: 8] = x[8*(7-i) +: 8];
    return y;
  endfunction
  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction
  // SHA-224 and SHA-256 share a schedule, so only the word size is kept
  assign unused_sha_lsb = &{1'b0, sha_type[0]};
  assign din = 1024'(s_axis_tdata);
  assign two_beat = mode64 && TWO_BEAT_BUS;
  assign fin_beat = !two_beat || beat;
  assign last_t = mode64 ? 7'd79 : 7'd63;
  assign fin_round = t == last_t;
  assign s_acc = s_axis_tvalid && s_axis_tready;
  assign m_hs = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata = win[0];
  assign m_axis_tuser = t;
  assign w_new = mode64 ? s1_64(win[14]) + win[9] + s0_64(win[1]) + win[0]
                        : {32'h0, s1_32(win[14][31:0]) + win[9][31:0] + s0_32(win[1][31:0]) + win[0][31:0]};
  // On a two-beat bus each beat carries eight 64-bit words for its half of the window
  always_comb begin
    for (int i = 0; i < 16; i++)
      ld[i] = mode64 ? bswap64(din[64*(TWO_BEAT_BUS ? i % 8 : i) +: 64]) : {32'h0, bswap32(din[32*i +: 32])};
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = en ? LOAD : IDLE;
      LOAD:    state_nx = (s_acc && fin_beat) ? EMIT : LOAD;
      EMIT:    state_nx = (m_hs && fin_round) ? (last_blk ? IDLE : LOAD) : EMIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      mode64 <= 1'b0;
      last_blk <= 1'b0;
      beat <= 1'b0;
      t <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      err <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      err <= 1'b0;
      if (state == IDLE && en) begin
        mode64 <= sha_type[1];
        beat <= 1'b0;
        s_axis_tready <= 1'b1;
      end
      if (s_acc) begin
        for (int i = 0; i < 16; i++)
          if (!two_beat || (i / 8) == int'(beat)) win[i] <= ld[i];
        beat <= !fin_beat;
        if (fin_beat) begin
          last_blk <= s_axis_tlast;
          s_axis_tready <= 1'b0;
          m_axis_tvalid <= 1'b1;
          m_axis_tlast <= 1'b0;
          t <= '0;
        end else err <= s_axis_tlast;
      end
      if (m_hs) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= w_new;
        t <= t + 7'd1;
        m_axis_tlast <= last_blk && (t + 7'd1 == last_t);
        if (fin_round) begin
          m_axis_tvalid <= 1'b0;
          s_axis_tready <= !last_blk;
        end
      end
    end
  end
endmodule
